sim_uart_in_source: RTL and testbench
=====================================

Name: sim_uart_in_source

Overview:
- Simulation-only character source that drives the SoC UART receive path, i.e. the `io_uart_in_valid`/`io_uart_in_ch` pair of the simulation top.
- A host side (DPI shim or bench) pushes bytes into an internal FIFO.
- The DUT's read strobe pops them, paced by a start-up hold and a minimum inter-character gap.
- When no character is available it returns the idle code, so it drops in where the constant-0xFF tie-off sits today.

Parameters:
- DEPTH, 16, FIFO entries; power of two, >=2.
- START_DELAY, 100, cycles after reset release before the first character may be returned; 0 = none.
- MIN_GAP, 0, idle cycles forced after each successful pop; 0 = back-to-back reads allowed.
- EMPTY_CH, 8'hFF, byte returned when nothing is deliverable.

Ports:
- clock  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- host_valid  in  1  host push request.
- host_ch  in  8  byte to push.
- host_ready  out  1  FIFO can accept a byte.
- uart_in_valid  in  1  DUT read strobe (from SimTop io_uart_in_valid).
- uart_in_ch  out  8  byte returned to DUT (to SimTop io_uart_in_ch).
- fifo_count  out  $clog2(DEPTH)+1  current occupancy.
- pop_count  out  32  characters delivered, wraps mod 2^32.
- empty_reads  out  32  strobes answered with EMPTY_CH, saturates at 32'hFFFF_FFFF.

Behaviour:
- Reset is synchronous, active-low: while reset==0 at posedge clock, all state clears.
  - FIFO empty, host_ready=0, uart_in_ch=EMPTY_CH, counters 0, state HOLD with timer=START_DELAY.
  - host_ready rises the first cycle after reset deasserts.
- FIFO: circular buffer with rd/wr pointers of $clog2(DEPTH)+1 bits; the MSB distinguishes full from empty.
  - host_ready = !full, combinational from registered state.
  - Push occurs when host_valid && host_ready at posedge.
  - host_valid while full is ignored; the byte is not stored and no error is raised.
- uart_in_ch is combinational, with zero-latency response in the same cycle as uart_in_valid:
  - FIFO head when state==ACTIVE && !empty;
  - EMPTY_CH otherwise.
- Pop: uart_in_valid && state==ACTIVE && !empty at posedge.
  - rd pointer advances and pop_count increments.
  - If MIN_GAP>0, go to GAP with timer=MIN_GAP-1; if MIN_GAP==0, remain ACTIVE.
- Empty read: uart_in_valid in any cycle where no pop occurs increments empty_reads, saturating.
- State machine:
  - HOLD: timer decrements each cycle; at timer==0 go to ACTIVE. START_DELAY==0 enters ACTIVE the first cycle after reset.
  - ACTIVE: deliver as above.
  - GAP: timer decrements; at timer==0 go to ACTIVE. Gap length is exactly MIN_GAP cycles during which reads return EMPTY_CH.
- No bypass: a byte pushed in cycle N is visible on uart_in_ch from cycle N+1 at the earliest.
- Simultaneous push and pop: both take effect; fifo_count is unchanged.
  - When full, host_ready is already 0, so a simultaneous pop does not admit a push that cycle.
- Pointer wrap-around is modulo 2*DEPTH. Data is never lost across the wrap.
- Reset asserted mid-operation discards FIFO contents, counters and any in-progress HOLD/GAP timing, and restarts HOLD.
- uart_in_valid is ignored during reset.
- All outputs are glitch-free functions of registers, except uart_in_ch, which also depends on registers only, not on uart_in_valid.

Decomposition:
- Shared package sim_uart_pkg:
  - state enum {HOLD, ACTIVE, GAP};
  - UART_IDLE_CH = 8'hFF;
  - type uart_byte_t = logic [7:0].
- One natural sub-module: sim_uart_fifo, a generic synchronous FIFO.
  - Parameter DEPTH.
  - Ports: push/pop, full/empty, head data, count.
  - The top holds the FSM, timers and counters.

Test Plan:
- Reset and start-up hold: START_DELAY=5; push 8'h41 at cycle 1 after reset; strobe every cycle.
  - Cycles 0-4 return 8'hFF and empty_reads counts them.
  - Cycle 5 returns 8'h41 and pop_count becomes 1.
- Ordering: START_DELAY=0, MIN_GAP=0; push "ABC" (41,42,43); strobe 3 consecutive cycles.
  - Returns 41,42,43, then 8'hFF; fifo_count ends at 0.
- Pacing: MIN_GAP=2; push 61,62; continuous strobes.
  - Sequence returned is 61,FF,FF,62,FF.
  - empty_reads increments on each FF.
- Full and back-pressure: DEPTH=4; push 5 bytes with no strobes.
  - host_ready drops after 4 pushes; the 5th byte is dropped; fifo_count=4.
  - Draining returns the first 4 bytes only.
- Wrap and simultaneous push/pop: DEPTH=4; 10 cycles of push+strobe with values 0..9 after priming 1 byte.
  - Output is the pushed order offset by one; fifo_count stays 1 throughout.
- Reset mid-operation: 3 bytes queued, MIN_GAP=3 while in GAP; assert reset for 1 cycle.
  - fifo_count=0, pop_count=0, state HOLD, uart_in_ch=8'hFF next cycle.
  - A new push is delivered only after START_DELAY.

Source files
------------

// File: rtl/sim_uart_pkg.sv
// sim_uart_pkg: shared types and constants for the simulation UART input source.
//   uart_byte_t  - one character on the UART receive path
//   UART_IDLE_CH - code returned when no character is deliverable
//   uart_state_e - delivery state machine states
package sim_uart_pkg;

  typedef logic [7:0] uart_byte_t;

  localparam uart_byte_t UART_IDLE_CH = 8'hFF;

  typedef enum logic [1:0] {
    HOLD   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2
  } uart_state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] satInc32(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/sim_uart_fifo.sv
// sim_uart_fifo: generic synchronous byte FIFO with a registered head.
// Ports:
//   clock, reset  - clock and synchronous active-low reset
//   push_i        - store data_i this cycle (ignored while full)
//   data_i        - byte to store
//   pop_i         - drop the head entry this cycle (ignored while empty)
//   full_o        - no free entry
//   empty_o       - no stored entry
//   head_o        - oldest stored byte (only meaningful when !empty_o)
//   count_o       - current occupancy, 0..DEPTH
module sim_uart_fifo
  import sim_uart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push_i,
  input  uart_byte_t             data_i,
  input  logic                   pop_i,
  output logic                   full_o,
  output logic                   empty_o,
  output uart_byte_t             head_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  typedef logic [AW:0] ptr_t;

  ptr_t       wrPtr_q, wrPtr_d;
  ptr_t       rdPtr_q, rdPtr_d;
  uart_byte_t mem_q [DEPTH];
  logic       doPush;
  logic       doPop;

  // Pointers carry one extra bit: equal indices with differing MSBs means
  // the writer has lapped the reader, i.e. full.
  assign full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign empty_o = (wrPtr_q == rdPtr_q);
  assign count_o = wrPtr_q - rdPtr_q;
  assign head_o  = mem_q[rdPtr_q[AW-1:0]];

  assign doPush = push_i && !full_o;
  assign doPop  = pop_i && !empty_o;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    if (doPush) wrPtr_d = wrPtr_q + ptr_t'(1);
    if (doPop)  rdPtr_d = rdPtr_q + ptr_t'(1);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
    end
  end

  // Storage needs no reset; only entries between the pointers are ever read.
  always_ff @(posedge clock) begin
    if (doPush) mem_q[wrPtr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/sim_uart_in_source.sv
// sim_uart_in_source: simulation-only character source for the SoC UART
// receive path. A host pushes bytes into a FIFO; the DUT's read strobe pops
// them, paced by a start-up hold and a minimum gap after each character.
// Ports:
//   clock, reset     - clock and synchronous active-low reset
//   host_valid_i     - host push request
//   host_ch_i        - byte to push
//   host_ready_o     - FIFO can accept a byte
//   uart_in_valid_i  - DUT read strobe
//   uart_in_ch_o     - byte returned to the DUT (EMPTY_CH when none deliverable)
//   fifo_count_o     - current FIFO occupancy
//   pop_count_o      - characters delivered, wraps
//   empty_reads_o    - strobes answered with EMPTY_CH, saturates
module sim_uart_in_source
  import sim_uart_pkg::*;
#(
  parameter int         DEPTH       = 16,
  parameter int         START_DELAY = 100,
  parameter int         MIN_GAP     = 0,
  parameter uart_byte_t EMPTY_CH    = UART_IDLE_CH
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   host_valid_i,
  input  uart_byte_t             host_ch_i,
  output logic                   host_ready_o,
  input  logic                   uart_in_valid_i,
  output uart_byte_t             uart_in_ch_o,
  output logic [$clog2(DEPTH):0] fifo_count_o,
  output logic [31:0]            pop_count_o,
  output logic [31:0]            empty_reads_o
);

  localparam int TIMER_MAX = (START_DELAY > MIN_GAP) ? START_DELAY : MIN_GAP;
  localparam int TW        = (TIMER_MAX < 2) ? 1 : $clog2(TIMER_MAX + 1);

  uart_state_e   state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          readyEn_q;
  logic [31:0]   popCount_q, popCount_d;
  logic [31:0]   emptyReads_q, emptyReads_d;

  logic          fifoFull;
  logic          fifoEmpty;
  uart_byte_t    fifoHead;
  logic          push;
  logic          pop;
  logic          deliverable;

  // readyEn_q keeps host_ready low for the cycle right after reset even
  // though the freshly cleared FIFO is not full.
  assign host_ready_o = readyEn_q && !fifoFull;
  assign push         = host_valid_i && host_ready_o;

  // Depends on registered state only, so the answer is ready in the same
  // cycle as the strobe without a path from uart_in_valid_i.
  assign deliverable  = (state_q == ACTIVE) && !fifoEmpty;
  assign uart_in_ch_o = deliverable ? fifoHead : EMPTY_CH;
  assign pop          = uart_in_valid_i && deliverable;

  assign pop_count_o   = popCount_q;
  assign empty_reads_o = emptyReads_q;

  sim_uart_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock  (clock),
    .reset  (reset),
    .push_i (push),
    .data_i (host_ch_i),
    .pop_i  (pop),
    .full_o (fifoFull),
    .empty_o(fifoEmpty),
    .head_o (fifoHead),
    .count_o(fifo_count_o)
  );

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    popCount_d   = popCount_q;
    emptyReads_d = emptyReads_q;

    unique case (state_q)
      // The cycle after reset already counts toward the hold, so the hold
      // ends once the timer reaches 1 and the first character is available
      // START_DELAY cycles after reset (or one cycle when START_DELAY is 0).
      HOLD: begin
        if (timer_q <= TW'(1)) begin
          state_d = ACTIVE;
          timer_d = '0;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      ACTIVE: begin
        if (pop && (MIN_GAP > 0)) begin
          state_d = GAP;
          timer_d = TW'(MIN_GAP - 1);
        end
      end
      GAP: begin
        if (timer_q == '0) begin
          state_d = ACTIVE;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: begin
        state_d = HOLD;
        timer_d = TW'(START_DELAY);
      end
    endcase

    if (pop) begin
      popCount_d = popCount_q + 32'd1;
    end else if (uart_in_valid_i) begin
      emptyReads_d = satInc32(emptyReads_q);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= HOLD;
      timer_q      <= TW'(START_DELAY);
      readyEn_q    <= 1'b0;
      popCount_q   <= '0;
      emptyReads_q <= '0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      readyEn_q    <= 1'b1;
      popCount_q   <= popCount_d;
      emptyReads_q <= emptyReads_d;
    end
  end

endmodule

// File: tb/tb_sim_uart_in_source.sv
// tb_sim_uart_in_source: self-checking bench for sim_uart_in_source.
// Two instances share the stimulus:
//   dut0: DEPTH=4, START_DELAY=5, MIN_GAP=2
//   dut1: DEPTH=4, START_DELAY=0, MIN_GAP=0
// Each instance is compared every cycle against a behavioural model that
// tracks a byte list plus "earliest cycle a character may be delivered".
module tb_sim_uart_in_source;

  localparam int NI  = 2;
  localparam int MSZ = 64;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       hostValid = 1'b0;
  logic [7:0] hostCh = 8'h00;
  logic       uartValid = 1'b0;

  logic        readyO [NI];
  logic [7:0]  chO    [NI];
  logic [2:0]  cntO   [NI];
  logic [31:0] popO   [NI];
  logic [31:0] emptyO [NI];

  int compared   = 0;
  int mismatched = 0;

  logic [7:0]  mBuf     [NI][MSZ];
  int          mHead    [NI];
  int          mSize    [NI];
  int          mCyc     [NI];
  int          mBlocked [NI];
  logic [31:0] mPop     [NI];
  logic [31:0] mEmpty   [NI];
  bit          modelValid = 1'b0;

  always #5 clock = ~clock;

  sim_uart_in_source #(
    .DEPTH(4), .START_DELAY(5), .MIN_GAP(2), .EMPTY_CH(8'hFF)
  ) dut0 (
    .clock          (clock),
    .reset          (reset),
    .host_valid_i   (hostValid),
    .host_ch_i      (hostCh),
    .host_ready_o   (readyO[0]),
    .uart_in_valid_i(uartValid),
    .uart_in_ch_o   (chO[0]),
    .fifo_count_o   (cntO[0]),
    .pop_count_o    (popO[0]),
    .empty_reads_o  (emptyO[0])
  );

  sim_uart_in_source #(
    .DEPTH(4), .START_DELAY(0), .MIN_GAP(0), .EMPTY_CH(8'hFF)
  ) dut1 (
    .clock          (clock),
    .reset          (reset),
    .host_valid_i   (hostValid),
    .host_ch_i      (hostCh),
    .host_ready_o   (readyO[1]),
    .uart_in_valid_i(uartValid),
    .uart_in_ch_o   (chO[1]),
    .fifo_count_o   (cntO[1]),
    .pop_count_o    (popO[1]),
    .empty_reads_o  (emptyO[1])
  );

  function automatic int depthOf(input int i);
    return 4;
  endfunction

  function automatic int startDelayOf(input int i);
    return (i == 0) ? 5 : 0;
  endfunction

  function automatic int minGapOf(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  task automatic checkEq(input string tag, input int i, input logic [31:0] obs,
                         input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s dut%0d: observed %0h expected %0h", tag, i, obs, exp);
    end
  endtask

  task automatic checkOutput();
    for (int i = 0; i < NI; i++) begin
      logic [7:0] expCh;
      logic       expReady;
      expCh    = (mCyc[i] >= mBlocked[i] && mSize[i] > 0) ? mBuf[i][mHead[i]] : 8'hFF;
      expReady = (mCyc[i] >= 1) && (mSize[i] < depthOf(i));
      checkEq("uart_in_ch", i, 32'(chO[i]), 32'(expCh));
      checkEq("host_ready", i, 32'(readyO[i]), 32'(expReady));
      checkEq("fifo_count", i, 32'(cntO[i]), 32'(mSize[i]));
      checkEq("pop_count", i, popO[i], mPop[i]);
      checkEq("empty_reads", i, emptyO[i], mEmpty[i]);
    end
  endtask

  // Model update for one clock edge, using the inputs held this cycle.
  task automatic modelEdge();
    for (int i = 0; i < NI; i++) begin
      bit deliv;
      bit canPush;
      int tail;
      if (!reset) begin
        mHead[i]    = 0;
        mSize[i]    = 0;
        mCyc[i]     = 0;
        mBlocked[i] = (startDelayOf(i) > 1) ? startDelayOf(i) : 1;
        mPop[i]     = 32'd0;
        mEmpty[i]   = 32'd0;
      end else begin
        deliv   = (mCyc[i] >= mBlocked[i]) && (mSize[i] > 0);
        canPush = (mCyc[i] >= 1) && (mSize[i] < depthOf(i));
        tail    = (mHead[i] + mSize[i]) % MSZ;
        if (uartValid) begin
          if (deliv) begin
            mHead[i]    = (mHead[i] + 1) % MSZ;
            mSize[i]    = mSize[i] - 1;
            mPop[i]     = mPop[i] + 32'd1;
            mBlocked[i] = mCyc[i] + 1 + minGapOf(i);
          end else if (mEmpty[i] != 32'hFFFF_FFFF) begin
            mEmpty[i] = mEmpty[i] + 32'd1;
          end
        end
        if (hostValid && canPush) begin
          mBuf[i][tail] = hostCh;
          mSize[i]      = mSize[i] + 1;
        end
        mCyc[i] = mCyc[i] + 1;
      end
    end
  endtask

  // One clock cycle: drive inputs, check at the falling edge, advance model.
  task automatic applyStimulus(input logic rst, input logic hv, input logic [7:0] hc,
                               input logic uv);
    reset     = rst;
    hostValid = hv;
    hostCh    = hc;
    uartValid = uv;
    @(negedge clock);
    if (modelValid) checkOutput();
    modelEdge();
    modelValid = 1'b1;
    @(posedge clock);
    #1;
  endtask

  initial begin
    @(posedge clock);
    #1;

    // Start-up hold: push 41 in cycle 1, strobe every cycle.
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
    applyStimulus(1'b1, 1'b1, 8'h41, 1'b1);
    for (int c = 2; c <= 4; c++) applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
    checkEq("startup_ch", 0, 32'(chO[0]), 32'h41);
    checkEq("startup_empty_reads", 0, emptyO[0], 32'd5);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
    checkEq("startup_pop_count", 0, popO[0], 32'd1);

    // Ordering: push "ABC", then strobe.
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'h41, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'h42, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'h43, 1'b0);
    for (int c = 0; c < 4; c++) applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
    checkEq("order_count_end", 1, 32'(cntO[1]), 32'd0);

    // Pacing: wait out the hold, push 61/62, continuous strobes.
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    for (int c = 0; c < 6; c++) applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'h61, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'h62, 1'b0);
    for (int c = 0; c < 6; c++) applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);

    // Full and back-pressure: five pushes into a four-entry FIFO.
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    for (int c = 0; c < 5; c++) applyStimulus(1'b1, 1'b1, 8'hA0 + 8'(c), 1'b0);
    for (int c = 0; c < 2; c++) applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    checkEq("full_count", 1, 32'(cntO[1]), 32'd4);
    checkEq("full_ready", 1, 32'(readyO[1]), 32'd0);
    for (int c = 0; c < 12; c++) applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);

    // Wrap with simultaneous push and pop after priming one byte.
    applyStimulus(1'b1, 1'b1, 8'h50, 1'b0);
    for (int c = 0; c < 10; c++) begin
      applyStimulus(1'b1, 1'b1, 8'(c), 1'b1);
      checkEq("wrap_count", 1, 32'(cntO[1]), 32'd1);
    end
    for (int c = 0; c < 10; c++) applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);

    // Reset mid-operation while dut0 sits in its gap.
    applyStimulus(1'b1, 1'b1, 8'hC1, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'hC2, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'hC3, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < NI; i++) begin
      checkEq("midreset_count", i, 32'(cntO[i]), 32'd0);
      checkEq("midreset_pop", i, popO[i], 32'd0);
      checkEq("midreset_ch", i, 32'(chO[i]), 32'hFF);
    end
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
    applyStimulus(1'b1, 1'b1, 8'hD1, 1'b1);
    for (int c = 0; c < 8; c++) applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 400; c++) begin
      applyStimulus(($urandom_range(0, 59) != 0), 1'($urandom_range(0, 1)),
                    8'($urandom), ($urandom_range(0, 2) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
